// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: controller FSM states and datapath widths
// common to the hazard controller, IF/ID register and branch predictor.
package pipeline_pkg;

  localparam int PC_W  = 5;
  localparam int GHR_W = 5;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FETCH_WAIT = 2'd1,
    RECOVER    = 2'd2
  } state_e;

endpackage

// File: rtl/spec_ghr.sv
// Speculative global history register. A restore from the EX checkpoint
// always beats a speculative shift in the same cycle.
module spec_ghr #(
  parameter int GHR_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             shift_bit,
  input  logic             restore_en,
  input  logic [GHR_W-1:0] restore_val,
  output logic [GHR_W-1:0] ghr
);

  logic [GHR_W-1:0] ghr_d, ghr_q;

  // next history: restore > shift > hold
  always_comb begin
    ghr_d = ghr_q;
    if (restore_en)    ghr_d = restore_val;
    else if (shift_en) ghr_d = {ghr_q[GHR_W-2:0], shift_bit};
  end

  // history register, cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end

  assign ghr = ghr_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer. Mispredict beats load-use beats fetch wait.
// Stall/flush/redirect outputs are combinational from state and inputs and
// are forced low while reset is held.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int PC_W          = pipeline_pkg::PC_W,
  parameter int GHR_W         = pipeline_pkg::GHR_W,
  parameter int FETCH_TIMEOUT = 15,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_ready,
  input  logic             is_branch_F,
  input  logic             prediction_F,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic             uses_rs1_D,
  input  logic             uses_rs2_D,
  input  logic             mem_read_E,
  input  logic [4:0]       rd_E,
  input  logic             branch_E,
  input  logic             taken_E,
  input  logic             prediction_E,
  input  logic [PC_W-1:0]  pc_E,
  input  logic [PC_W-1:0]  target_E,
  input  logic [GHR_W-1:0] ghr_E,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             flush_E,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [GHR_W-1:0] ghr_F,
  output logic             fetch_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] mispredicts
);

  localparam int               WAIT_W   = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(FETCH_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_e            state_d, state_q;
  logic [WAIT_W-1:0] wait_cnt_d, wait_cnt_q;
  logic              fetch_error_d, fetch_error_q;
  logic [CNT_W-1:0]  stall_cycles_d, stall_cycles_q;
  logic [CNT_W-1:0]  mispredicts_d, mispredicts_q;

  logic mispredict, load_use, fetch_wait, ghr_shift;
  logic rs1_hit, rs2_hit;

  // hazard detection; EX holds a bubble during RECOVER so branch_E is ignored
  always_comb begin
    rs1_hit    = uses_rs1_D & (rs1_D == rd_E);
    rs2_hit    = uses_rs2_D & (rs2_D == rd_E);
    mispredict = reset & branch_E & (taken_E ^ prediction_E) & (state_q != RECOVER);
    load_use   = reset & mem_read_E & (|rd_E) & (rs1_hit | rs2_hit);
    fetch_wait = reset & ~imem_ready & ~mispredict & ~load_use;
  end

  // FSM next state and prioritised control outputs
  always_comb begin
    state_d        = state_q;
    stall_F        = 1'b0;
    stall_D        = 1'b0;
    flush_D        = 1'b0;
    flush_E        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    if (mispredict) begin
      redirect_valid = 1'b1;
      redirect_pc    = taken_E ? target_E : pc_E + PC_W'(1);
      flush_D        = 1'b1;
      flush_E        = 1'b1;
    end else if (load_use) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end else if (fetch_wait) begin
      // hold PC and feed decode a bubble instead of holding IF/ID
      stall_F = 1'b1;
      flush_D = 1'b1;
    end

    // the ID slot still holds the killed path for one cycle after redirect
    if (reset && state_q == RECOVER) flush_E = 1'b1;

    case (state_q)
      RUN, FETCH_WAIT: begin
        if (mispredict)       state_d = RECOVER;
        else if (!imem_ready) state_d = FETCH_WAIT;
        else                  state_d = RUN;
      end
      RECOVER: state_d = imem_ready ? RUN : FETCH_WAIT;
      default: state_d = RUN;
    endcase
  end

  // fetch wait counter, sticky timeout flag and saturating perf counters
  always_comb begin
    wait_cnt_d     = wait_cnt_q;
    fetch_error_d  = fetch_error_q;
    stall_cycles_d = stall_cycles_q;
    mispredicts_d  = mispredicts_q;

    if (mispredict || imem_ready)
      wait_cnt_d = '0;
    else if (fetch_wait && wait_cnt_q != WAIT_MAX)
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);

    if (wait_cnt_d == WAIT_MAX) fetch_error_d = 1'b1;

    if (stall_F && stall_cycles_q != CNT_MAX)
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (mispredict && mispredicts_q != CNT_MAX)
      mispredicts_d = mispredicts_q + CNT_W'(1);
  end

  // state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      fetch_error_q  <= 1'b0;
      stall_cycles_q <= '0;
      mispredicts_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      fetch_error_q  <= fetch_error_d;
      stall_cycles_q <= stall_cycles_d;
      mispredicts_q  <= mispredicts_d;
    end
  end

  // speculative shift only for a branch that actually enters IF/ID
  assign ghr_shift = is_branch_F & imem_ready & ~stall_F & ~mispredict;

  spec_ghr #(.GHR_W(GHR_W)) u_spec_ghr (
    .clk         (clk),
    .reset       (reset),
    .shift_en    (ghr_shift),
    .shift_bit   (prediction_F),
    .restore_en  (mispredict),
    .restore_val ({ghr_E[GHR_W-2:0], taken_E}),
    .ghr         (ghr_F)
  );

  assign fetch_error  = fetch_error_q;
  assign stall_cycles = stall_cycles_q;
  assign mispredicts  = mispredicts_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. CNT_W is shrunk to 4 so counter
// saturation is reachable inside the fetch-timeout scenario.
module tb_pipeline_hazard_ctrl;

  localparam int PC_W  = 5;
  localparam int GHR_W = 5;
  localparam int FT    = 15;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             imem_ready, is_branch_F, prediction_F;
  logic [4:0]       rs1_D, rs2_D, rd_E;
  logic             uses_rs1_D, uses_rs2_D, mem_read_E;
  logic             branch_E, taken_E, prediction_E;
  logic [PC_W-1:0]  pc_E, target_E;
  logic [GHR_W-1:0] ghr_E;
  logic             stall_F, stall_D, flush_D, flush_E, redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic [GHR_W-1:0] ghr_F;
  logic             fetch_error;
  logic [CNT_W-1:0] stall_cycles, mispredicts;
  logic [4:0]       ctl;

  int vectors = 0;
  int miscompares = 0;

  // {stall_F, stall_D, flush_D, flush_E, redirect_valid}
  assign ctl = {stall_F, stall_D, flush_D, flush_E, redirect_valid};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .PC_W(PC_W), .GHR_W(GHR_W), .FETCH_TIMEOUT(FT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .imem_ready(imem_ready),
    .is_branch_F(is_branch_F), .prediction_F(prediction_F),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .uses_rs1_D(uses_rs1_D), .uses_rs2_D(uses_rs2_D),
    .mem_read_E(mem_read_E), .rd_E(rd_E), .branch_E(branch_E), .taken_E(taken_E),
    .prediction_E(prediction_E), .pc_E(pc_E), .target_E(target_E), .ghr_E(ghr_E),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ghr_F(ghr_F),
    .fetch_error(fetch_error), .stall_cycles(stall_cycles), .mispredicts(mispredicts)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    imem_ready = 1'b1; is_branch_F = 1'b0; prediction_F = 1'b0;
    rs1_D = '0; rs2_D = '0; uses_rs1_D = 1'b0; uses_rs2_D = 1'b0;
    mem_read_E = 1'b0; rd_E = '0; branch_E = 1'b0; taken_E = 1'b0;
    prediction_E = 1'b0; pc_E = '0; target_E = '0; ghr_E = '0;
  endtask

  task automatic test_reset();
    idle();
    #1;
    vectors++; if (ctl !== 5'b00000) begin miscompares++; $display("FAIL reset_held_ctl: got %b want %b", ctl, 5'b00000); end
    vectors++; if (ghr_F !== 5'b00000) begin miscompares++; $display("FAIL reset_held_ghr: got %b want %b", ghr_F, 5'b00000); end
    tick();
    reset = 1'b1;
    #1;
    vectors++; if (ctl !== 5'b00000) begin miscompares++; $display("FAIL reset_rel_ctl: got %b want %b", ctl, 5'b00000); end
    vectors++; if ({fetch_error, stall_cycles, mispredicts} !== 9'd0) begin miscompares++; $display("FAIL reset_rel_cnt: got %b/%0d/%0d want 0/0/0", fetch_error, stall_cycles, mispredicts); end
  endtask

  task automatic test_ghr_shift();
    is_branch_F = 1'b1; prediction_F = 1'b1;
    tick();
    vectors++; if (ghr_F !== 5'b00001) begin miscompares++; $display("FAIL ghr_shift1: got %b want %b", ghr_F, 5'b00001); end
    tick();
    vectors++; if (ghr_F !== 5'b00011) begin miscompares++; $display("FAIL ghr_shift2: got %b want %b", ghr_F, 5'b00011); end
    tick();
    vectors++; if (ghr_F !== 5'b00111) begin miscompares++; $display("FAIL ghr_shift3: got %b want %b", ghr_F, 5'b00111); end
    idle();
  endtask

  task automatic test_load_use();
    // rs2 hit, with a fetched branch that must not shift while stalled
    mem_read_E = 1'b1; rd_E = 5'd3; rs2_D = 5'd3; uses_rs2_D = 1'b1;
    is_branch_F = 1'b1; prediction_F = 1'b0;
    #1;
    vectors++; if (ctl !== 5'b11010) begin miscompares++; $display("FAIL lu_rs2_ctl: got %b want %b", ctl, 5'b11010); end
    tick();
    idle();
    #1;
    vectors++; if (ctl !== 5'b00000) begin miscompares++; $display("FAIL lu_clear_ctl: got %b want %b", ctl, 5'b00000); end
    vectors++; if (stall_cycles !== 4'd1) begin miscompares++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cycles); end
    vectors++; if (ghr_F !== 5'b00111) begin miscompares++; $display("FAIL lu_ghr_hold: got %b want %b", ghr_F, 5'b00111); end
    // rd_E == x0 never stalls
    mem_read_E = 1'b1; rd_E = 5'd0; rs1_D = 5'd0; uses_rs1_D = 1'b1;
    #1;
    vectors++; if (ctl !== 5'b00000) begin miscompares++; $display("FAIL lu_x0: got %b want %b", ctl, 5'b00000); end
    // matching register that is not read
    rd_E = 5'd7; rs1_D = 5'd1; rs2_D = 5'd7; uses_rs1_D = 1'b1; uses_rs2_D = 1'b0;
    #1;
    vectors++; if (ctl !== 5'b00000) begin miscompares++; $display("FAIL lu_unused: got %b want %b", ctl, 5'b00000); end
    // rs1 hit
    rs1_D = 5'd7;
    #1;
    vectors++; if (ctl !== 5'b11010) begin miscompares++; $display("FAIL lu_rs1_ctl: got %b want %b", ctl, 5'b11010); end
    // not a load
    mem_read_E = 1'b0;
    #1;
    vectors++; if (ctl !== 5'b00000) begin miscompares++; $display("FAIL lu_noload: got %b want %b", ctl, 5'b00000); end
    idle();
  endtask

  task automatic test_mispredict();
    branch_E = 1'b1; taken_E = 1'b0; prediction_E = 1'b1;
    pc_E = 5'd31; target_E = 5'd20; ghr_E = 5'b10110;
    #1;
    vectors++; if (ctl !== 5'b00111) begin miscompares++; $display("FAIL mp_ctl: got %b want %b", ctl, 5'b00111); end
    vectors++; if (redirect_pc !== 5'd0) begin miscompares++; $display("FAIL mp_wrap_pc: got %0d want 0", redirect_pc); end
    tick();
    // branch_E left asserted: must be ignored in RECOVER
    #1;
    vectors++; if (ctl !== 5'b00010) begin miscompares++; $display("FAIL mp_recover_ctl: got %b want %b", ctl, 5'b00010); end
    vectors++; if (ghr_F !== 5'b01100) begin miscompares++; $display("FAIL mp_ghr_restore: got %b want %b", ghr_F, 5'b01100); end
    vectors++; if (mispredicts !== 4'd1) begin miscompares++; $display("FAIL mp_cnt1: got %0d want 1", mispredicts); end
    tick();
    idle();
    #1;
    vectors++; if (ctl !== 5'b00000) begin miscompares++; $display("FAIL mp_run_ctl: got %b want %b", ctl, 5'b00000); end
    vectors++; if (mispredicts !== 4'd1) begin miscompares++; $display("FAIL mp_recover_ignore: got %0d want 1", mispredicts); end
    // correctly predicted branch: nothing happens
    branch_E = 1'b1; taken_E = 1'b1; prediction_E = 1'b1; target_E = 5'd17;
    #1;
    vectors++; if (ctl !== 5'b00000) begin miscompares++; $display("FAIL mp_correct: got %b want %b", ctl, 5'b00000); end
    // taken mispredict redirects to target
    prediction_E = 1'b0; ghr_E = 5'b00001;
    #1;
    vectors++; if (redirect_pc !== 5'd17 || redirect_valid !== 1'b1) begin miscompares++; $display("FAIL mp_taken_pc: got %b/%0d want 1/17", redirect_valid, redirect_pc); end
    tick();
    idle();
    #1;
    vectors++; if (ghr_F !== 5'b00011) begin miscompares++; $display("FAIL mp_taken_ghr: got %b want %b", ghr_F, 5'b00011); end
    vectors++; if (mispredicts !== 4'd2) begin miscompares++; $display("FAIL mp_cnt2: got %0d want 2", mispredicts); end
    tick();
  endtask

  task automatic test_back_to_back();
    // mispredict + load-use + fetched branch in one cycle
    branch_E = 1'b1; taken_E = 1'b1; prediction_E = 1'b0; target_E = 5'd9; ghr_E = 5'b01010;
    mem_read_E = 1'b1; rd_E = 5'd3; rs1_D = 5'd3; uses_rs1_D = 1'b1;
    is_branch_F = 1'b1; prediction_F = 1'b0;
    #1;
    vectors++; if (ctl !== 5'b00111) begin miscompares++; $display("FAIL coinc_ctl: got %b want %b", ctl, 5'b00111); end
    vectors++; if (redirect_pc !== 5'd9) begin miscompares++; $display("FAIL coinc_pc: got %0d want 9", redirect_pc); end
    tick();
    idle();
    #1;
    vectors++; if (ghr_F !== 5'b10101) begin miscompares++; $display("FAIL coinc_ghr: got %b want %b", ghr_F, 5'b10101); end
    vectors++; if (stall_cycles !== 4'd1 || mispredicts !== 4'd3) begin miscompares++; $display("FAIL coinc_cnt: got %0d/%0d want 1/3", stall_cycles, mispredicts); end
    tick();
  endtask

  task automatic test_fetch_timeout();
    logic       exp_err;
    logic [3:0] exp_sc;
    imem_ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      vectors++; if (ctl !== 5'b10100) begin miscompares++; $display("FAIL fw_ctl[%0d]: got %b want %b", k, ctl, 5'b10100); end
      tick();
      exp_err = (k >= FT);
      exp_sc  = (1 + k > 15) ? 4'd15 : 4'(1 + k);
      vectors++; if (fetch_error !== exp_err) begin miscompares++; $display("FAIL fw_err[%0d]: got %b want %b", k, fetch_error, exp_err); end
      vectors++; if (stall_cycles !== exp_sc) begin miscompares++; $display("FAIL fw_stall_sat[%0d]: got %0d want %0d", k, stall_cycles, exp_sc); end
    end
    imem_ready = 1'b1;
    #1;
    vectors++; if (ctl !== 5'b00000) begin miscompares++; $display("FAIL fw_ready_ctl: got %b want %b", ctl, 5'b00000); end
    tick();
    vectors++; if (fetch_error !== 1'b1) begin miscompares++; $display("FAIL fw_sticky: got %b want 1", fetch_error); end
    reset = 1'b0;
    #1;
    vectors++; if ({fetch_error, stall_cycles, mispredicts, ghr_F} !== 14'd0) begin miscompares++; $display("FAIL fw_reset_clear: got %b/%0d/%0d/%b want 0/0/0/00000", fetch_error, stall_cycles, mispredicts, ghr_F); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_wait_mispredict();
    imem_ready = 1'b0;
    repeat (10) tick();
    branch_E = 1'b1; taken_E = 1'b0; prediction_E = 1'b1; pc_E = 5'd4; ghr_E = 5'b00000;
    #1;
    vectors++; if (ctl !== 5'b00111 || redirect_pc !== 5'd5) begin miscompares++; $display("FAIL wm_ctl: got %b/%0d want 00111/5", ctl, redirect_pc); end
    tick();
    idle();
    #1;
    vectors++; if (ctl !== 5'b00010) begin miscompares++; $display("FAIL wm_recover: got %b want %b", ctl, 5'b00010); end
    vectors++; if (mispredicts !== 4'd1) begin miscompares++; $display("FAIL wm_cnt: got %0d want 1", mispredicts); end
    tick();
    // the wait counter must have restarted from zero
    imem_ready = 1'b0;
    repeat (14) tick();
    vectors++; if (fetch_error !== 1'b0) begin miscompares++; $display("FAIL wm_cnt_cleared: got %b want 0", fetch_error); end
    tick();
    vectors++; if (fetch_error !== 1'b1) begin miscompares++; $display("FAIL wm_timeout15: got %b want 1", fetch_error); end
    idle();
    tick();
  endtask

  task automatic test_reset_recover();
    branch_E = 1'b1; taken_E = 1'b1; prediction_E = 1'b0; target_E = 5'd12; ghr_E = 5'b11111;
    tick();
    idle();
    #1;
    vectors++; if (ctl !== 5'b00010 || ghr_F !== 5'b11111) begin miscompares++; $display("FAIL rr_recover: got %b/%b want 00010/11111", ctl, ghr_F); end
    reset = 1'b0;
    #1;
    vectors++; if (ctl !== 5'b00000) begin miscompares++; $display("FAIL rr_async_ctl: got %b want %b", ctl, 5'b00000); end
    vectors++; if ({fetch_error, mispredicts, ghr_F} !== 10'd0) begin miscompares++; $display("FAIL rr_async_state: got %b/%0d/%b want 0/0/00000", fetch_error, mispredicts, ghr_F); end
    tick();
    reset = 1'b1;
    #1;
    vectors++; if (ctl !== 5'b00000) begin miscompares++; $display("FAIL rr_release_ctl: got %b want %b", ctl, 5'b00000); end
    tick();
    vectors++; if (ctl !== 5'b00000 || mispredicts !== 4'd0) begin miscompares++; $display("FAIL rr_run: got %b/%0d want 00000/0", ctl, mispredicts); end
  endtask

  initial begin
    test_reset();
    test_ghr_shift();
    test_load_use();
    test_mispredict();
    test_back_to_back();
    test_fetch_timeout();
    test_wait_mispredict();
    test_reset_recover();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
